enc_rd_ctrl: RTL and testbench
==============================

ENC_RD_CTRL -- requirements
Module: enc_rd_ctrl

Interface
REQ-001 SHALL have parameter LANES, default 4, legal 1..8, meaning bytes encoded per clock, lane 0 transmitted first.
REQ-002 SHALL have parameter RD_INIT, default 1'b0, meaning running disparity after reset (0 = RD-, 1 = RD+).
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning reset; asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1 bit, meaning the input word is valid.
REQ-006 SHALL have port in_ready, output, 1 bit, meaning the block accepts the word this cycle.
REQ-007 SHALL have port in_cls6, input, 2*LANES bits, meaning the 5b/6b disparity class per lane (enc_dcls_t).
REQ-008 SHALL have port in_cls4, input, 2*LANES bits, meaning the 3b/4b disparity class per lane (enc_dcls_t).
REQ-009 SHALL have port out_valid, output, 1 bit, meaning the output word is valid.
REQ-010 SHALL have port out_ready, input, 1 bit, meaning the downstream consumer accepts the output word.
REQ-011 SHALL have port compl6, output, LANES bits, meaning complement the 6b sub-block of lane i.
REQ-012 SHALL have port compl4, output, LANES bits, meaning complement the 4b sub-block of lane i.
REQ-013 SHALL have port rd_lane, output, LANES bits, meaning running disparity after lane i.
REQ-014 SHALL have port cls_err, output, LANES bits, meaning lane i carried a reserved class.

Function
REQ-015 SHALL define classes: DC_BAL=0 (never complemented, RD unchanged), DC_BAL_ALT=1 (complemented when entry RD+, RD unchanged), DC_UNBAL=2 (primary is +2; complemented when entry RD+; RD toggles), DC_RSVD=3 (handled as DC_BAL with cls_err set).
REQ-016 SHALL chain sub-blocks in the order lane0 6b, lane0 4b, lane1 6b, ...; each sub-block's entry RD is the exit RD of the previous sub-block, and lane0 6b enters with the RD register.
REQ-017 SHALL transfer input when in_valid and in_ready are both high, and output when out_valid and out_ready are both high.
REQ-018 SHALL drive in_ready = ~out_valid | out_ready (one register stage, no combinational path from in_valid to outputs).
REQ-019 SHALL present the results of an accepted word on the outputs with out_valid high in the next cycle (latency 1).
REQ-020 SHALL hold all outputs stable while out_valid=1 and out_ready=0.
REQ-021 SHALL load the RD register with rd_lane[LANES-1] of the accepted word only on an input transfer; otherwise RD holds.
REQ-022 SHALL clear out_valid after an output transfer that has no simultaneous input transfer; a simultaneous input and output transfer SHALL keep out_valid=1 with new data.

Reset
REQ-023 SHALL, while rst=1, asynchronously force out_valid=0, compl6=0, compl4=0, cls_err=0, rd_lane={LANES{RD_INIT}}, and RD register=RD_INIT.
REQ-024 SHALL discard an in-flight output word when rst is asserted mid-operation, and the first word after reset SHALL use RD_INIT.

Configuration
REQ-025 SHALL, with macro ENC_RD_FORCE_EN defined, add inputs rd_force (1 bit) and rd_force_val (1 bit).
REQ-026 SHALL, under ENC_RD_FORCE_EN, have a word accepted in a cycle where rd_force=1 use rd_force_val as its lane0 entry RD.
REQ-027 SHALL, under ENC_RD_FORCE_EN, load rd_force_val into the RD register when rd_force=1 in a cycle with no input transfer.
REQ-028 SHALL, without ENC_RD_FORCE_EN, omit both ports and leave the RD register affected only by reset and transfers.

Structure
REQ-029 SHALL place enc_dcls_t and the DC_* constants in the shared package enc8b10b_pkg.
REQ-030 SHALL implement one sub-block step (class, entry RD -> compl, exit RD, err) as the combinational sub-module enc_rd_step, instantiated 2*LANES times.

Verification
REQ-031 SHALL verify: LANES=2, RD-, all classes DC_UNBAL -> compl6=2'b00, compl4=2'b11, rd_lane=2'b00, next RD-.
REQ-032 SHALL verify: LANES=2, RD+, all classes DC_BAL_ALT -> compl6=2'b11, compl4=2'b11, rd_lane=2'b11.
REQ-033 SHALL verify: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen, RD unchanged; release -> one word per cycle.
REQ-034 SHALL verify: lane1 cls6=3 -> cls_err=2'b10, lane handled as DC_BAL.
REQ-035 SHALL verify: rst pulsed mid-stream -> out_valid=0 immediately; first following word enters RD_INIT.
REQ-036 SHALL verify: under ENC_RD_FORCE_EN, rd_force=1 with rd_force_val=1 and a DC_UNBAL lane0 6b -> compl6[0]=1.

Source files
------------

// File: rtl/enc8b10b_pkg.sv
// Shared 8b/10b encoder types: disparity classes of 5b/6b and 3b/4b
// sub-blocks, used by the running-disparity controller and its steps.
package enc8b10b_pkg;

  typedef enum logic [1:0] {
    DC_BAL     = 2'd0,
    DC_BAL_ALT = 2'd1,
    DC_UNBAL   = 2'd2,
    DC_RSVD    = 2'd3
  } enc_dcls_t;

  localparam int ENC_LANES_MAX = 8;

  // Exit disparity of one sub-block given its class and entry RD.
  function automatic logic rd_next(input enc_dcls_t c, input logic rd);
    return (c == DC_UNBAL) ? ~rd : rd;
  endfunction

endpackage

// File: rtl/enc_rd_step.sv
// One sub-block disparity step: class + entry RD -> complement, exit RD, err.
// Ports: i_cls, i_rd in; o_compl, o_rd, o_err out. Purely combinational.
module enc_rd_step
  import enc8b10b_pkg::*;
(
  input  enc_dcls_t i_cls,
  input  logic      i_rd,
  output logic      o_compl,
  output logic      o_rd,
  output logic      o_err
);

  always_comb begin
    o_compl = 1'b0;
    o_rd    = rd_next(i_cls, i_rd);
    o_err   = 1'b0;
    unique case (i_cls)
      DC_BAL:     o_compl = 1'b0;
      DC_BAL_ALT: o_compl = i_rd;
      DC_UNBAL:   o_compl = i_rd;
      DC_RSVD:    o_err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/enc_rd_ctrl.sv
// 8b/10b running-disparity controller: per-lane complement decisions,
// one register stage with valid/ready on both sides.
// Ports: clk, rst (async high), in_valid/in_ready, in_cls6/in_cls4,
// out_valid/out_ready, compl6, compl4, rd_lane, cls_err.
// Option: ENC_RD_FORCE_EN adds rd_force/rd_force_val to override RD.
module enc_rd_ctrl
  import enc8b10b_pkg::*;
#(
  parameter int   LANES   = 4,
  parameter logic RD_INIT = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*LANES-1:0] in_cls6,
  input  logic [2*LANES-1:0] in_cls4,
`ifdef ENC_RD_FORCE_EN
  input  logic               rd_force,
  input  logic               rd_force_val,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES-1:0]   compl6,
  output logic [LANES-1:0]   compl4,
  output logic [LANES-1:0]   rd_lane,
  output logic [LANES-1:0]   cls_err
);

  logic             r_rd;
  logic             r_out_valid;
  logic [LANES-1:0] r_compl6;
  logic [LANES-1:0] r_compl4;
  logic [LANES-1:0] r_rd_lane;
  logic [LANES-1:0] r_cls_err;

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_rd_entry;
  logic             w_rd_chain [0:2*LANES];
  enc_dcls_t        w_cls6 [LANES];
  enc_dcls_t        w_cls4 [LANES];
  logic [LANES-1:0] w_c6;
  logic [LANES-1:0] w_c4;
  logic [LANES-1:0] w_e6;
  logic [LANES-1:0] w_e4;
  logic [LANES-1:0] w_rdl;

  assign in_ready   = ~r_out_valid | out_ready;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = r_out_valid & out_ready;

`ifdef ENC_RD_FORCE_EN
  assign w_rd_entry = rd_force ? rd_force_val : r_rd;
`else
  assign w_rd_entry = r_rd;
`endif

  assign w_rd_chain[0] = w_rd_entry;

  // Chain order: lane0 6b, lane0 4b, lane1 6b, ...
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_cls6[g] = enc_dcls_t'(in_cls6[2*g +: 2]);
    assign w_cls4[g] = enc_dcls_t'(in_cls4[2*g +: 2]);

    enc_rd_step u_s6 (
      .i_cls   (w_cls6[g]),
      .i_rd    (w_rd_chain[2*g]),
      .o_compl (w_c6[g]),
      .o_rd    (w_rd_chain[2*g+1]),
      .o_err   (w_e6[g])
    );

    enc_rd_step u_s4 (
      .i_cls   (w_cls4[g]),
      .i_rd    (w_rd_chain[2*g+1]),
      .o_compl (w_c4[g]),
      .o_rd    (w_rd_chain[2*g+2]),
      .o_err   (w_e4[g])
    );

    assign w_rdl[g] = w_rd_chain[2*g+2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd        <= RD_INIT;
      r_out_valid <= 1'b0;
      r_compl6    <= '0;
      r_compl4    <= '0;
      r_rd_lane   <= {LANES{RD_INIT}};
      r_cls_err   <= '0;
    end else if (w_in_xfer) begin
      r_rd        <= w_rd_chain[2*LANES];
      r_out_valid <= 1'b1;
      r_compl6    <= w_c6;
      r_compl4    <= w_c4;
      r_rd_lane   <= w_rdl;
      r_cls_err   <= w_e6 | w_e4;
    end else begin
      if (w_out_xfer) r_out_valid <= 1'b0;
`ifdef ENC_RD_FORCE_EN
      if (rd_force) r_rd <= rd_force_val;
`endif
    end
  end

  assign out_valid = r_out_valid;
  assign compl6    = r_compl6;
  assign compl4    = r_compl4;
  assign rd_lane   = r_rd_lane;
  assign cls_err   = r_cls_err;

endmodule

// File: tb/tb_enc_rd_ctrl.sv
// Self-checking bench for enc_rd_ctrl (LANES=2, RD_INIT=0): directed
// scenarios plus randomized traffic against a behavioural model.
module tb_enc_rd_ctrl;

  localparam int L = 2;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2*L-1:0] in_cls6;
  logic [2*L-1:0] in_cls4;
  logic         out_valid;
  logic         out_ready;
  logic [L-1:0] compl6;
  logic [L-1:0] compl4;
  logic [L-1:0] rd_lane;
  logic [L-1:0] cls_err;
`ifdef ENC_RD_FORCE_EN
  logic         rd_force;
  logic         rd_force_val;
`endif

  int n_run;
  int n_fail;

  typedef struct {
    logic [L-1:0] c6;
    logic [L-1:0] c4;
    logic [L-1:0] rdl;
    logic [L-1:0] err;
  } exp_t;

  exp_t q[$];

  enc_rd_ctrl #(.LANES(L), .RD_INIT(1'b0)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_cls6      (in_cls6),
    .in_cls4      (in_cls4),
`ifdef ENC_RD_FORCE_EN
    .rd_force     (rd_force),
    .rd_force_val (rd_force_val),
`endif
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .compl6       (compl6),
    .compl4       (compl4),
    .rd_lane      (rd_lane),
    .cls_err      (cls_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout run=%0d", n_run);
    $fatal(1);
  end

  // Walk the sub-blocks in transmit order, tracking disparity as an
  // integer: an unbalanced primary adds +2, its complement -2.
  function automatic exp_t model(input logic [2*L-1:0] c6,
                                 input logic [2*L-1:0] c4,
                                 input bit rd_in, output bit rd_out);
    exp_t e;
    int   disp;
    int   cls;
    disp = rd_in ? 1 : -1;
    e.c6 = '0; e.c4 = '0; e.rdl = '0; e.err = '0;
    for (int l = 0; l < L; l++) begin
      for (int s = 0; s < 2; s++) begin
        cls = (s == 0) ? int'(c6[2*l +: 2]) : int'(c4[2*l +: 2]);
        if (cls == 3) e.err[l] = 1'b1;
        if ((cls == 1 || cls == 2) && disp > 0) begin
          if (s == 0) e.c6[l] = 1'b1;
          else        e.c4[l] = 1'b1;
        end
        if (cls == 2) disp = (disp > 0) ? disp - 2 : disp + 2;
      end
      e.rdl[l] = (disp > 0);
    end
    rd_out = (disp > 0);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    n_run++; if (compl6 !== 2'b00 || compl4 !== 2'b00) begin n_fail++; $display("FAIL rst_compl got=%b/%b exp=00/00", compl6, compl4); end
    n_run++; if (rd_lane !== 2'b00) begin n_fail++; $display("FAIL rst_rdlane got=%b exp=00", rd_lane); end
    n_run++; if (cls_err !== 2'b00) begin n_fail++; $display("FAIL rst_err got=%b exp=00", cls_err); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_unbal();
    in_valid = 1'b1; in_cls6 = 4'b1010; in_cls4 = 4'b1010; out_ready = 1'b1;
    tick();
    n_run++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL unbal_valid got=%b exp=1", out_valid); end
    n_run++; if (compl6 !== 2'b00 || compl4 !== 2'b11) begin n_fail++; $display("FAIL unbal_compl got=%b/%b exp=00/11", compl6, compl4); end
    n_run++; if (rd_lane !== 2'b00) begin n_fail++; $display("FAIL unbal_rdlane got=%b exp=00", rd_lane); end
    in_cls6 = 4'b0010; in_cls4 = 4'b0000;
    tick();
    n_run++; if (compl6 !== 2'b00 || rd_lane !== 2'b11) begin n_fail++; $display("FAIL unbal_next_rd got=%b/%b exp=00/11", compl6, rd_lane); end
    in_valid = 1'b0;
    tick();
    n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL unbal_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_bal_alt();
    in_valid = 1'b1; in_cls6 = 4'b0101; in_cls4 = 4'b0101;
    tick();
    in_valid = 1'b0;
    n_run++; if (compl6 !== 2'b11 || compl4 !== 2'b11) begin n_fail++; $display("FAIL balalt_compl got=%b/%b exp=11/11", compl6, compl4); end
    n_run++; if (rd_lane !== 2'b11) begin n_fail++; $display("FAIL balalt_rdlane got=%b exp=11", rd_lane); end
    tick();
  endtask

  task automatic test_rsvd();
    in_valid = 1'b1; in_cls6 = 4'b1100; in_cls4 = 4'b0100;
    tick();
    in_valid = 1'b0;
    n_run++; if (cls_err !== 2'b10) begin n_fail++; $display("FAIL rsvd_err got=%b exp=10", cls_err); end
    n_run++; if (compl6 !== 2'b00 || compl4 !== 2'b10) begin n_fail++; $display("FAIL rsvd_compl got=%b/%b exp=00/10", compl6, compl4); end
    n_run++; if (rd_lane !== 2'b11) begin n_fail++; $display("FAIL rsvd_rdlane got=%b exp=11", rd_lane); end
    tick();
  endtask

  task automatic test_stall();
    in_valid = 1'b1; in_cls6 = 4'b0010; in_cls4 = 4'b0000; out_ready = 1'b0;
    tick();
    in_cls6 = 4'b1010; in_cls4 = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_run++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready c%0d got=%b exp=0", i, in_ready); end
      tick();
      n_run++; if (out_valid !== 1'b1 || compl6 !== 2'b01 || compl4 !== 2'b00 || rd_lane !== 2'b00) begin
        n_fail++; $display("FAIL stall_hold c%0d got=%b/%b/%b/%b exp=1/01/00/00", i, out_valid, compl6, compl4, rd_lane);
      end
    end
    out_ready = 1'b1;
    tick();
    n_run++; if (out_valid !== 1'b1 || compl6 !== 2'b00 || compl4 !== 2'b11 || rd_lane !== 2'b00) begin
      n_fail++; $display("FAIL stall_rel1 got=%b/%b/%b/%b exp=1/00/11/00", out_valid, compl6, compl4, rd_lane);
    end
    in_cls6 = 4'b0010; in_cls4 = 4'b0000;
    tick();
    n_run++; if (out_valid !== 1'b1 || compl6 !== 2'b00 || rd_lane !== 2'b11) begin
      n_fail++; $display("FAIL stall_rel2 got=%b/%b/%b exp=1/00/11", out_valid, compl6, rd_lane);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_cls6 = 4'b0000; in_cls4 = 4'b0000; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_run++; if (out_valid !== 1'b0 || rd_lane !== 2'b00) begin n_fail++; $display("FAIL midrst_async got=%b/%b exp=0/00", out_valid, rd_lane); end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_cls6 = 4'b0010;
    tick();
    in_valid = 1'b0;
    n_run++; if (compl6 !== 2'b00 || rd_lane !== 2'b11) begin n_fail++; $display("FAIL midrst_rdinit got=%b/%b exp=00/11", compl6, rd_lane); end
    tick();
  endtask

`ifdef ENC_RD_FORCE_EN
  task automatic test_force();
    rd_force = 1'b1; rd_force_val = 1'b0; in_valid = 1'b0;
    tick();
    rd_force = 1'b0;
    in_valid = 1'b1; in_cls6 = 4'b0000; in_cls4 = 4'b0001;
    tick();
    n_run++; if (compl4 !== 2'b00) begin n_fail++; $display("FAIL force_load got=%b exp=00", compl4); end
    rd_force = 1'b1; rd_force_val = 1'b1; in_cls6 = 4'b0010; in_cls4 = 4'b0000;
    tick();
    rd_force = 1'b0; in_valid = 1'b0;
    n_run++; if (compl6 !== 2'b01 || rd_lane !== 2'b00) begin n_fail++; $display("FAIL force_word got=%b/%b exp=01/00", compl6, rd_lane); end
    tick();
  endtask
`endif

  task automatic test_random();
    bit   rd_m;
    bit   rd_o;
    exp_t e;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    #1 rst = 1'b0;
    rd_m = 1'b0;
    q.delete();
    tick();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      in_cls6   = 4'($urandom);
      in_cls4   = 4'($urandom);
      @(negedge clk);
      n_run++; if (out_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid c%0d got=%b exp=%b", c, out_valid, q.size() != 0); end
      n_run++; if (in_ready !== ((q.size() == 0) || out_ready)) begin n_fail++; $display("FAIL rnd_ready c%0d got=%b", c, in_ready); end
      if (q.size() != 0) begin
        e = q[0];
        n_run++; if (compl6 !== e.c6 || compl4 !== e.c4 || rd_lane !== e.rdl || cls_err !== e.err) begin
          n_fail++; $display("FAIL rnd_data c%0d got=%b/%b/%b/%b exp=%b/%b/%b/%b", c, compl6, compl4, rd_lane, cls_err, e.c6, e.c4, e.rdl, e.err);
        end
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && q.size() == 0) begin
        q.push_back(model(in_cls6, in_cls4, rd_m, rd_o));
        rd_m = rd_o;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_drain got=%b exp=0", out_valid); end
  endtask

  initial begin
    n_run = 0; n_fail = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_cls6 = '0; in_cls4 = '0;
`ifdef ENC_RD_FORCE_EN
    rd_force = 1'b0; rd_force_val = 1'b0;
`endif
    test_reset();
    test_unbal();
    test_bal_alt();
    test_rsvd();
    test_stall();
    test_reset_mid();
`ifdef ENC_RD_FORCE_EN
    test_force();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
